// File: rtl/core_pkg.sv
// Shared xiao-rv core definitions: fetch FSM encoding and fetch-related constants.
package core_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWait,
    StHold,
    StKill
  } fetch_state_t;

  localparam int unsigned PC_STEP = 4;

  localparam logic [31:0] INST_FAULT_WORD = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, keeps one imem request outstanding and hands
// instructions to decode through a valid/ready hold register.
module fetch_unit
  import core_pkg::*;
#(
  parameter int unsigned   AW       = 32,
  parameter int unsigned   DW       = 32,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_gnt,
  input  logic          imem_rsp_valid,
  input  logic [DW-1:0] imem_rsp_data,
  input  logic          imem_rsp_err,
  output logic          inst_valid,
  output logic [DW-1:0] inst,
  output logic [AW-1:0] inst_pc,
  output logic          inst_err,
  input  logic          inst_ready,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_pc
);

  fetch_state_t  state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [DW-1:0] inst_q, inst_d;
  logic          inst_err_q, inst_err_d;
  logic [AW-1:0] redirect_target;
  logic          unused_redirect_lsb;

  assign redirect_target     = {redirect_pc[AW-1:2], 2'b00};
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
    inst_err_d = inst_err_q;

    unique case (state_q)
      StIdle: state_d = StReq;

      // An ungranted request may retarget; a granted one becomes stale on redirect.
      StReq: begin
        if (redirect_valid) pc_d = redirect_target;
        if (imem_gnt) state_d = redirect_valid ? StKill : StWait;
      end

      StWait: begin
        if (imem_rsp_valid) begin
          if (redirect_valid) begin
            pc_d    = redirect_target;
            state_d = StReq;
          end else begin
            inst_d     = imem_rsp_err ? DW'(INST_FAULT_WORD) : imem_rsp_data;
            inst_err_d = imem_rsp_err;
            state_d    = StHold;
          end
        end else if (redirect_valid) begin
          pc_d    = redirect_target;
          state_d = StKill;
        end
      end

      StKill: begin
        if (redirect_valid) pc_d = redirect_target;
        if (imem_rsp_valid) state_d = StReq;
      end

      // Redirect wins over a same-cycle handoff.
      StHold: begin
        if (redirect_valid) begin
          pc_d    = redirect_target;
          state_d = StReq;
        end else if (inst_ready) begin
          pc_d    = pc_q + AW'(PC_STEP);
          state_d = StReq;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      pc_q       <= RESET_PC;
      inst_q     <= '0;
      inst_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inst_q     <= inst_d;
      inst_err_q <= inst_err_d;
    end
  end

  assign imem_req   = (state_q == StReq);
  assign imem_addr  = imem_req ? pc_q : '0;
  assign inst_valid = (state_q == StHold);
  assign inst_pc    = inst_valid ? pc_q : '0;
  assign inst       = inst_q;
  assign inst_err   = inst_err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random traffic, checked every
// cycle against a transaction-level model of the fetch protocol.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        imem_rsp_err = 1'b0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_err;
  logic        inst_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fetch_unit #(
    .AW      (32),
    .DW      (32),
    .RESET_PC(RST_PC)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .imem_rsp_err  (imem_rsp_err),
    .inst_valid    (inst_valid),
    .inst          (inst),
    .inst_pc       (inst_pc),
    .inst_err      (inst_err),
    .inst_ready    (inst_ready),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Protocol-level model: a request is either being presented, in flight
  // (possibly stale), or its instruction is being held for decode.
  bit          m_boot = 1'b1;
  bit          m_pres = 1'b0;
  bit          m_infl = 1'b0;
  bit          m_stale = 1'b0;
  bit          m_have = 1'b0;
  logic [31:0] m_pc = RST_PC;
  logic [31:0] m_inst = '0;
  logic        m_err = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    logic [31:0] tgt;
    tgt = redirect_pc & ~32'h3;
    if (!rst_n) begin
      m_boot = 1'b1; m_pres = 1'b0; m_infl = 1'b0; m_stale = 1'b0; m_have = 1'b0;
      m_pc = RST_PC; m_inst = '0; m_err = 1'b0;
    end else if (m_boot) begin
      m_boot = 1'b0;
      m_pres = 1'b1;
    end else if (m_pres) begin
      if (redirect_valid) m_pc = tgt;
      if (imem_gnt) begin
        m_pres  = 1'b0;
        m_infl  = 1'b1;
        m_stale = redirect_valid;
      end
    end else if (m_infl) begin
      if (imem_rsp_valid) begin
        m_infl = 1'b0;
        if (m_stale || redirect_valid) begin
          if (redirect_valid) m_pc = tgt;
          m_pres = 1'b1;
        end else begin
          m_have = 1'b1;
          m_inst = imem_rsp_err ? 32'h0 : imem_rsp_data;
          m_err  = imem_rsp_err;
        end
      end else if (redirect_valid) begin
        m_pc    = tgt;
        m_stale = 1'b1;
      end
    end else if (m_have) begin
      if (redirect_valid) begin
        m_pc = tgt; m_have = 1'b0; m_pres = 1'b1;
      end else if (inst_ready) begin
        m_pc = m_pc + 32'd4; m_have = 1'b0; m_pres = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    chk("imem_req", imem_req, m_pres);
    if (m_pres) chk("imem_addr", imem_addr, m_pc);
    chk("inst_valid", inst_valid, m_have);
    if (m_have) begin
      chk("inst_pc", inst_pc, m_pc);
      chk("inst", inst, m_inst);
      chk("inst_err", inst_err, m_err);
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_req"}, imem_req, 0);
    chk({tag, "_addr"}, imem_addr, 0);
    chk({tag, "_valid"}, inst_valid, 0);
    chk({tag, "_inst"}, inst, 0);
    chk({tag, "_pc"}, inst_pc, 0);
    chk({tag, "_err"}, inst_err, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk_reset("reset");

    // Sequential fetch, grant always, response one cycle later, decode always ready.
    rst_n = 1'b1; imem_gnt = 1'b1; imem_rsp_valid = 1'b1; inst_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      imem_rsp_data = 32'hA000_0000 + k;
      step();
      chk("seq_req", imem_req, 1);
      chk("seq_addr", imem_addr, RST_PC + 32'(4 * k));
      step();
      step();
      chk("seq_valid", inst_valid, 1);
      chk("seq_pc", inst_pc, RST_PC + 32'(4 * k));
      chk("seq_inst", inst, 32'hA000_0000 + k);
      if (k == 2) inst_ready = 1'b0;
    end

    // Back-pressure on the held instruction.
    imem_rsp_data = 32'h5555_5555;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_valid", inst_valid, 1);
      chk("bp_pc", inst_pc, 32'h108);
      chk("bp_inst", inst, 32'hA000_0002);
      chk("bp_err", inst_err, 0);
      chk("bp_req", imem_req, 0);
    end
    inst_ready = 1'b1;
    step();
    chk("bp_next", imem_addr, 32'h10C);

    // Redirect in WAIT, response arrives two cycles later and must be dropped.
    imem_rsp_valid = 1'b0;
    step();
    imem_gnt = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h2002;
    step();
    chk("kill_valid0", inst_valid, 0);
    redirect_valid = 1'b0;
    step();
    chk("kill_valid1", inst_valid, 0);
    imem_rsp_valid = 1'b1;
    step();
    chk("kill_valid2", inst_valid, 0);
    chk("kill_addr", imem_addr, 32'h2000);

    // Ungranted retarget to 0x200, then redirect in HOLD alongside inst_ready.
    imem_rsp_valid = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h200;
    step();
    chk("retarget_addr", imem_addr, 32'h200);
    redirect_valid = 1'b0; imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'hBEEF_0200;
    step();
    chk("hold_pc", inst_pc, 32'h200);
    imem_rsp_valid = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h400; inst_ready = 1'b1;
    step();
    chk("hredir_valid", inst_valid, 0);
    chk("hredir_addr", imem_addr, 32'h400);

    // Faulting fetch at the top of the address space, then wrap.
    redirect_pc = 32'hFFFF_FFFE;
    step();
    chk("wrap_req_addr", imem_addr, 32'hFFFF_FFFC);
    redirect_valid = 1'b0; imem_gnt = 1'b1; inst_ready = 1'b0;
    step();
    imem_gnt = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_err = 1'b1; imem_rsp_data = 32'h1234_5678;
    step();
    chk("fault_err", inst_err, 1);
    chk("fault_inst", inst, 32'h0);
    chk("fault_pc", inst_pc, 32'hFFFF_FFFC);
    imem_rsp_valid = 1'b0; imem_rsp_err = 1'b0; inst_ready = 1'b1;
    step();
    chk("wrap_addr", imem_addr, 32'h0);

    // Asynchronous reset while waiting; a response after release is ignored.
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk_reset("areset");
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
    rst_n = 1'b1;
    step();
    chk("rst_req", imem_req, 1);
    chk("rst_addr", imem_addr, RST_PC);
    step();
    chk("rst_ignored", inst_valid, 0);
    chk("rst_addr2", imem_addr, RST_PC);

    // Random traffic checked by the model.
    for (int c = 0; c < 4000; c++) begin
      imem_gnt       = ($urandom_range(0, 1) == 1);
      imem_rsp_valid = ($urandom_range(0, 1) == 1);
      imem_rsp_err   = ($urandom_range(0, 7) == 0);
      imem_rsp_data  = $urandom;
      inst_ready     = ($urandom_range(0, 1) == 1);
      redirect_valid = ($urandom_range(0, 7) == 0);
      redirect_pc    = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : $urandom;
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
